// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Fixed 34-cycle busy window per operation, regardless of op or operands.
module mdu_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     flush,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out,
    output logic                     we_out
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [5:0]               count;
    logic [2:0]               fn;
    logic [W-1:0]             a_reg;
    logic [W-1:0]             b_reg;
    logic [ADDRESS_WIDTH-1:0] rd_reg;
    // acc_hi: product high half / partial remainder; acc_lo: multiplier / quotient.
    logic [W-1:0]             acc_hi;
    logic [W-1:0]             acc_lo;
    logic [W-1:0]             mcand;

    function automatic logic signed_a(input logic [2:0] f);
        return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f);
        return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
    endfunction

    // Operand magnitudes taken at launch
    logic         a_neg_in;
    logic         b_neg_in;
    logic [W-1:0] a_mag_in;
    logic [W-1:0] b_mag_in;

    assign a_neg_in = signed_a(funct3) & op_a[W-1];
    assign b_neg_in = signed_b(funct3) & op_b[W-1];
    assign a_mag_in = a_neg_in ? (~op_a + 1'b1) : op_a;
    assign b_mag_in = b_neg_in ? (~op_b + 1'b1) : op_b;

    // One iteration step for each algorithm
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic         div_ge;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_diff  = div_shift - {1'b0, mcand};

    // Sign correction and special cases, evaluated in FIN
    logic           a_neg;
    logic           b_neg;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s;
    logic [W-1:0]   rem_s;
    logic           b_zero;
    logic           sdiv_ovf;
    logic [W-1:0]   fin_value;

    assign a_neg    = signed_a(fn) & a_reg[W-1];
    assign b_neg    = signed_b(fn) & b_reg[W-1];
    assign prod     = {acc_hi, acc_lo};
    assign prod_s   = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    assign quot_s   = (a_neg ^ b_neg) ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_s    = a_neg ? (~acc_hi + 1'b1) : acc_hi;
    assign b_zero   = (b_reg == '0);
    assign sdiv_ovf = (a_reg == {1'b1, {(W-1){1'b0}}}) && (b_reg == '1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fin_value = '0;
        case (fn)
            F_MUL:                      fin_value = prod_s[W-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fin_value = prod_s[2*W-1:W];
            F_DIV:  fin_value = b_zero ? '1 : (sdiv_ovf ? {1'b1, {(W-1){1'b0}}} : quot_s);
            F_DIVU: fin_value = b_zero ? '1 : acc_lo;
            F_REM:  fin_value = b_zero ? a_reg : (sdiv_ovf ? '0 : rem_s);
            F_REMU: fin_value = b_zero ? a_reg : acc_hi;
            default: fin_value = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = CALC;
                CALC: if (count == 6'(W-1)) state_next = FIN;
                FIN:  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy   = (state != IDLE);
        done   = (state == DONE);
        we_out = (state == DONE) && (rd_out != '0);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            fn     <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            rd_reg <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fn     <= funct3;
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        rd_reg <= rd_in;
                        count  <= '0;
                        acc_hi <= '0;
                        acc_lo <= funct3[2] ? a_mag_in : b_mag_in;
                        mcand  <= funct3[2] ? b_mag_in : a_mag_in;
                    end
                end
                CALC: begin
                    count <= count + 6'd1;
                    if (fn[2]) begin
                        acc_hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[W:1];
                        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                    end
                end
                FIN: begin
                    result <= fin_value;
                    rd_out <= rd_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, corner sequences
// (ignored starts, flush, mid-operation reset) and random ops against a 64-bit arithmetic model.
module tb_mdu_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    mdu_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: RV32M semantics via wide integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub_l;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_l = longint'(ub);
        ia   = a;
        ib   = b;
        p    = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub_l; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Launch one op, expect done exactly 33 edges after the accepting edge
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input bit noise);
        int n;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        check({name, " busy_on_start"}, 64'(busy), 64'd1);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = noise && (n == 5 || n == 20);
            if (start) begin
                funct3 = 3'($urandom_range(0, 7));
                op_a = $urandom; op_b = $urandom; rd_in = 5'd31;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(n), 64'd33);
        check({name, " result"}, 64'(result), 64'(exp));
        check({name, " rd_out"}, 64'(rd_out), 64'(rd));
        check({name, " we_out"}, 64'(we_out), 64'(rd != 0));
        @(posedge clk); #1;
        check({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
        check({name, " result_held"}, 64'(result), 64'(exp));
    endtask

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_f;
    logic [4:0]  r_rd;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd2,  32'hFFFF_FFFD};
        vecs[3]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'd123,        32'd0,         5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd7, 32'd123,        32'd0,         5'd7,  32'd123};
        vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000};
        vecs[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0};
        vecs[9]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd10, 32'h4000_0000};
        vecs[10] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd11, 32'hFFFF_FFFF};
        vecs[11] = '{3'd5, 32'd100,        32'd7,         5'd0,  32'd14};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, we_out, result, rd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b0);

        // Starts pulsed mid-operation must be ignored
        do_op("ignore_start", 3'd0, 32'd3, 32'd5, 5'd2, 32'd15, 1'b1);

        // Flush at edge 10 of a DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush busy", {62'd0, busy, done}, 64'd0);
        check("flush result kept", 64'(result), 64'd15);
        flush = 1'b0;
        do_op("after_flush", 3'd5, 32'd1000, 32'd3, 5'd12, 32'd333, 1'b0);

        // Asynchronous reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy, done, we_out, result, rd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 5'd1, 32'd12, 1'b0);

        // Random ops against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            r_f  = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            r_rd = 5'($urandom_range(0, 31));
            do_op($sformatf("rand%0d f%0d", k, r_f), r_f, r_a, r_b, r_rd, model(r_f, r_a, r_b), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, meaning destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a new operation.
REQ-006 SHALL have port flush  input  1  abort the in-flight operation.
REQ-007 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port op_a  input  DATA_WIDTH  rs1 value (register file RD1).
REQ-009 SHALL have port op_b  input  DATA_WIDTH  rs2 value (register file RD2).
REQ-010 SHALL have port rd_in  input  ADDRESS_WIDTH  destination register index.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-013 SHALL have port result  output  DATA_WIDTH  registered result (register file WD3).
REQ-014 SHALL have port rd_out  output  ADDRESS_WIDTH  registered destination index (register file AD3).
REQ-015 SHALL have port we_out  output  1  write enable (register file WE3); high only when done=1 and rd_out!=0.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIN, DONE; the 6-bit iteration counter SHALL be internal.
REQ-017 In IDLE with start=1 and flush=0, SHALL latch funct3, op_a, op_b, rd_in, clear the counter, and move to CALC on that edge.
REQ-018 SHALL ignore start while busy=1; latched operands SHALL NOT change until the operation completes or is flushed.
REQ-019 In CALC, SHALL perform one radix-2 iteration per cycle on operand magnitudes, using shift-add for multiply and restoring shift-subtract for divide, for exactly 32 cycles, then move to FIN.
REQ-020 In FIN, SHALL apply sign correction and special cases, register result and rd_out, and move to DONE.
REQ-021 In DONE, SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-022 Latency SHALL be fixed for every op and operand: start sampled at edge 0 -> done high in the cycle after edge 33; busy high for 34 cycles.
REQ-023 A start sampled in DONE SHALL be ignored; back-to-back throughput SHALL be one operation per 35 cycles.
REQ-024 MUL SHALL return the low 32 bits of the product; MULH, MULHSU and MULHU SHALL return the high 32 bits of the 64-bit product.
REQ-025 MULH SHALL treat both operands as signed; MULHSU SHALL treat op_a as signed and op_b as unsigned; MULHU SHALL treat both as unsigned.
REQ-026 DIV and REM SHALL be signed; the quotient SHALL truncate toward zero and the remainder sign SHALL follow the dividend.
REQ-027 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return op_a.
REQ-028 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-029 Special cases SHALL NOT alter the latency.
REQ-030 flush=1 SHALL force IDLE on the next edge from any state with no done pulse; flush SHALL take priority over start.
REQ-031 result and rd_out SHALL hold their last values until the next FIN.
REQ-032 done and we_out SHALL be driven from registered state only, with no combinational path from the inputs.

Reset
REQ-033 On rst_n=0, SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, we_out=0, result=0, rd_out=0, and discard any operation in flight.
REQ-034 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Verification
REQ-035 MUL 7 x 0xFFFFFFFD, rd_in=5 -> done at cycle 34, result=0xFFFFFFEB, rd_out=5, we_out=1; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-037 DIVU 123 / 0 -> 0xFFFFFFFF; REMU 123 / 0 -> 123; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-038 Any op with rd_in=0 -> done pulses, we_out stays 0; start pulsed at cycles 5 and 20 during busy -> ignored, result unchanged.
REQ-039 flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done pulse, result keeps its prior value; a new start at cycle 11 completes normally.
REQ-040 rst_n low at cycle 15 of a MUL -> outputs zero immediately, no done; after release, MUL 3 x 4 -> 12.
